// File: rtl/axi_slv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_slv_pkg
// Purpose  : Shared types for the AXI3 slave write controller: burst type
//            enum, response codes and controller state enum.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package axi_slv_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/axi_slv_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_slv_wr_ctrl_if
// Purpose  : AXI3 write address / write data / write response channels.
// Ports    : none; modport master drives AW*, W*, BREADY,
//            modport slave drives AWREADY, WREADY, BID, BRESP, BVALID.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_slv_wr_ctrl_if;
  import axi_slv_pkg::*;

  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    output BREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    input  BREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID
  );

endinterface
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_addr_gen
// Purpose  : Next beat address for FIXED / INCR / WRAP bursts.
// Ports    : addr_i      current beat byte address
//            size_i      log2 bytes per beat
//            len_i       beats minus one
//            burst_i     burst type
//            next_addr_o address of the following beat
// Revision : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
  import axi_slv_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [2:0]  size_i,
  input  logic [3:0]  len_i,
  input  burst_e      burst_i,
  output logic [31:0] next_addr_o
);

  logic [31:0] w_step;
  logic [31:0] w_incr;
  logic [31:0] w_wrap_mask;

  assign w_step      = 32'd1 << size_i;
  assign w_incr      = addr_i + w_step;
  // Wrap window is (len+1) beats wide; keep the window base, wrap the offset.
  assign w_wrap_mask = ((32'(len_i) + 32'd1) << size_i) - 32'd1;

  always_comb begin
    next_addr_o = addr_i;
    case (burst_i)
      BURST_INCR: next_addr_o = w_incr;
      BURST_WRAP: next_addr_o = (addr_i & ~w_wrap_mask) | (w_incr & w_wrap_mask);
      default:    next_addr_o = addr_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_slv_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_slv_wr_ctrl
// Purpose  : AXI3 write-only slave with an internal word memory, one
//            outstanding transaction, protocol error detection (SLVERR).
// Ports    : clk        clock, rising edge
//            rst        asynchronous active-low reset
//            bus        AXI write channels (slave modport)
//            dbg_addr   backdoor word index
//            dbg_rdata  combinational memory word at dbg_addr
// Revision : 1.0 - initial release
// ============================================================================
module axi_slv_wr_ctrl
  import axi_slv_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  axi_slv_wr_ctrl_if.slave             bus,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [31:0]                  dbg_rdata
);

  localparam int c_AW = $clog2(MEM_DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  burst_e      burst_q, burst_d;
  logic [3:0]  beat_q, beat_d;
  logic        err_q, err_d;
  logic        sup_q, sup_d;       // burst-level error: no beat is written
  logic        awready_q, awready_d;

  logic [31:0] mem_q [MEM_DEPTH];

  logic [31:0] w_next_addr;
  logic        w_mem_we;
  logic        w_aw_err;
  logic        w_wrap_len_ok;
  logic [31:0] w_align_mask;
  logic        w_beat_last;
  logic        w_wlast_err;
  logic        w_wid_err;
  logic        w_range_err;

  axi_burst_addr_gen u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (w_next_addr)
  );

  // Burst-level checks, evaluated on the AW channel inputs.
  assign w_wrap_len_ok = (bus.AWLEN == 4'd1) || (bus.AWLEN == 4'd3) ||
                         (bus.AWLEN == 4'd7) || (bus.AWLEN == 4'd15);
  assign w_align_mask  = (32'd1 << bus.AWSIZE) - 32'd1;
  assign w_aw_err      = (bus.AWSIZE > 3'd2) ||
                         (bus.AWBURST == BURST_RSVD) ||
                         ((bus.AWBURST == BURST_WRAP) &&
                          (!w_wrap_len_ok || ((bus.AWADDR & w_align_mask) != 32'd0)));

  // Beat-level checks, evaluated against the latched burst.
  assign w_beat_last = (beat_q == len_q);
  assign w_wlast_err = (bus.WLAST != w_beat_last);
  assign w_wid_err   = (bus.WID != id_q);
  assign w_range_err = (addr_q[31:2] >= 30'(MEM_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      beat_q    <= '0;
      err_q     <= 1'b0;
      sup_q     <= 1'b0;
      awready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      sup_q     <= sup_d;
      awready_q <= awready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    err_d    = err_q;
    sup_d    = sup_q;
    w_mem_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // awready_q is low for the first cycle after reset release.
        if (bus.AWVALID && awready_q) begin
          id_d    = bus.AWID;
          addr_d  = bus.AWADDR;
          len_d   = bus.AWLEN;
          size_d  = bus.AWSIZE;
          burst_d = burst_e'(bus.AWBURST);
          beat_d  = '0;
          err_d   = w_aw_err;
          sup_d   = w_aw_err;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.WVALID) begin
          w_mem_we = !sup_q && !w_wid_err && !w_range_err;
          if (w_wlast_err || w_wid_err || w_range_err) begin
            err_d = 1'b1;
          end
          beat_d = beat_q + 4'd1;
          addr_d = w_next_addr;
          if (w_beat_last) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (bus.BREADY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    awready_d = (state_d == ST_IDLE);
  end

  // Memory has no reset: contents survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.WSTRB[b]) begin
          mem_q[addr_q[c_AW+1:2]][8*b +: 8] <= bus.WDATA[8*b +: 8];
        end
      end
    end
  end

  assign dbg_rdata   = mem_q[dbg_addr];

  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = (state_q == ST_DATA);
  assign bus.BVALID  = (state_q == ST_RESP);
  assign bus.BID     = id_q;
  assign bus.BRESP   = err_q ? RESP_SLVERR : RESP_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_axi_slv_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_slv_wr_ctrl
// Purpose  : Directed self-checking bench for axi_slv_wr_ctrl.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_slv_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata;
  int          n_vec = 0;
  int          n_err = 0;

  axi_slv_wr_ctrl_if bus ();

  axi_slv_wr_ctrl #(.MEM_DEPTH(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bus.AWID    = id;
    bus.AWADDR  = addr;
    bus.AWLEN   = len;
    bus.AWSIZE  = size;
    bus.AWBURST = burst;
    bus.AWVALID = 1'b1;
    for (int i = 0; i < 20 && !bus.AWREADY; i++) begin
      @(posedge clk); #1;
    end
    check_val("awready", {31'd0, bus.AWREADY}, 32'd1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                      input logic last);
    bus.WID    = id;
    bus.WDATA  = data;
    bus.WSTRB  = strb;
    bus.WLAST  = last;
    bus.WVALID = 1'b1;
    for (int i = 0; i < 20 && !bus.WREADY; i++) begin
      @(posedge clk); #1;
    end
    check_val("wready", {31'd0, bus.WREADY}, 32'd1);
    @(posedge clk); #1;
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
  endtask

  task automatic do_b(input logic [3:0] exp_id, input logic [1:0] exp_resp);
    for (int i = 0; i < 20 && !bus.BVALID; i++) begin
      @(posedge clk); #1;
    end
    check_val("bvalid", {31'd0, bus.BVALID}, 32'd1);
    check_val("bid",    {28'd0, bus.BID},    {28'd0, exp_id});
    check_val("bresp",  {30'd0, bus.BRESP},  {30'd0, exp_resp});
    bus.BREADY = 1'b1;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] wa, input logic [31:0] exp);
    dbg_addr = wa;
    #1;
    check_val(tag, dbg_rdata, exp);
  endtask

  initial begin
    rst         = 1'b0;
    dbg_addr    = '0;
    bus.AWID    = '0;
    bus.AWADDR  = '0;
    bus.AWLEN   = '0;
    bus.AWSIZE  = '0;
    bus.AWBURST = '0;
    bus.AWVALID = 1'b0;
    bus.WID     = '0;
    bus.WDATA   = '0;
    bus.WSTRB   = '0;
    bus.WLAST   = 1'b0;
    bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_awready", {31'd0, bus.AWREADY}, 32'd0);
    check_val("rst_wready",  {31'd0, bus.WREADY},  32'd0);
    check_val("rst_bvalid",  {31'd0, bus.BVALID},  32'd0);
    check_val("rst_bid",     {28'd0, bus.BID},     32'd0);
    check_val("rst_bresp",   {30'd0, bus.BRESP},   32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rel_awready", {31'd0, bus.AWREADY}, 32'd1);

    // INCR 0x10, 4 beats
    do_aw(4'h6, 32'h10, 4'd3, 3'd2, 2'd1);
    check_val("aw_lat_wready",  {31'd0, bus.WREADY},  32'd1);
    check_val("aw_lat_awready", {31'd0, bus.AWREADY}, 32'd0);
    do_w(4'h6, 32'hA0, 4'hF, 1'b0);
    do_w(4'h6, 32'hA1, 4'hF, 1'b0);
    do_w(4'h6, 32'hA2, 4'hF, 1'b0);
    do_w(4'h6, 32'hA3, 4'hF, 1'b1);
    check_val("w_lat_bvalid", {31'd0, bus.BVALID}, 32'd1);
    do_b(4'h6, 2'd0);
    check_val("b_done_awready", {31'd0, bus.AWREADY}, 32'd1);
    rd_chk("incr_w4", 8'd4, 32'hA0);
    rd_chk("incr_w5", 8'd5, 32'hA1);
    rd_chk("incr_w6", 8'd6, 32'hA2);
    rd_chk("incr_w7", 8'd7, 32'hA3);

    // WRAP 0x38: 0x38, 0x3C, 0x30, 0x34
    do_aw(4'h1, 32'h38, 4'd3, 3'd2, 2'd2);
    do_w(4'h1, 32'hB0, 4'hF, 1'b0);
    do_w(4'h1, 32'hB1, 4'hF, 1'b0);
    do_w(4'h1, 32'hB2, 4'hF, 1'b0);
    do_w(4'h1, 32'hB3, 4'hF, 1'b1);
    do_b(4'h1, 2'd0);
    rd_chk("wrap_w14", 8'd14, 32'hB0);
    rd_chk("wrap_w15", 8'd15, 32'hB1);
    rd_chk("wrap_w12", 8'd12, 32'hB2);
    rd_chk("wrap_w13", 8'd13, 32'hB3);

    // Clear word 0, then FIXED with byte strobes
    do_aw(4'h2, 32'h0, 4'd0, 3'd2, 2'd1);
    do_w(4'h2, 32'h0, 4'hF, 1'b1);
    do_b(4'h2, 2'd0);
    do_aw(4'h2, 32'h0, 4'd1, 3'd2, 2'd0);
    do_w(4'h2, 32'h11, 4'h1, 1'b0);
    do_w(4'h2, 32'h2200, 4'h2, 1'b1);
    do_b(4'h2, 2'd0);
    rd_chk("fixed_w0", 8'd0, 32'h0000_2211);

    // Early WLAST on beat 1 of a 4-beat burst
    do_aw(4'h3, 32'h40, 4'd3, 3'd2, 2'd1);
    do_w(4'h3, 32'hD0, 4'hF, 1'b0);
    do_w(4'h3, 32'hD1, 4'hF, 1'b1);
    do_w(4'h3, 32'hD2, 4'hF, 1'b0);
    do_w(4'h3, 32'hD3, 4'hF, 1'b1);
    do_b(4'h3, 2'd2);

    // WID mismatch: beat with WID=5 must not be written
    do_aw(4'h3, 32'h54, 4'd0, 3'd2, 2'd1);
    do_w(4'h3, 32'hDEAD, 4'hF, 1'b1);
    do_b(4'h3, 2'd0);
    do_aw(4'h3, 32'h50, 4'd1, 3'd2, 2'd1);
    do_w(4'h3, 32'hC0, 4'hF, 1'b0);
    do_w(4'h5, 32'hC1, 4'hF, 1'b1);
    do_b(4'h3, 2'd2);
    rd_chk("wid_w20", 8'd20, 32'hC0);
    rd_chk("wid_w21", 8'd21, 32'hDEAD);

    // AWSIZE > 2 suppresses the write
    do_aw(4'h0, 32'h90, 4'd0, 3'd2, 2'd1);
    do_w(4'h0, 32'h1234_5678, 4'hF, 1'b1);
    do_b(4'h0, 2'd0);
    do_aw(4'h0, 32'h90, 4'd0, 3'd3, 2'd1);
    do_w(4'h0, 32'h77, 4'hF, 1'b1);
    do_b(4'h0, 2'd2);
    rd_chk("size_w36", 8'd36, 32'h1234_5678);

    // Word index 256 is out of range; word 0 must not be touched
    do_aw(4'h7, 32'h400, 4'd0, 3'd2, 2'd1);
    do_w(4'h7, 32'h55, 4'hF, 1'b1);
    do_b(4'h7, 2'd2);
    rd_chk("range_w0", 8'd0, 32'h0000_2211);

    // Reserved burst type
    do_aw(4'h4, 32'h20, 4'd0, 3'd2, 2'd3);
    do_w(4'h4, 32'h66, 4'hF, 1'b1);
    do_b(4'h4, 2'd2);

    // BREADY held low: {BVALID,BID,BRESP,AWREADY} = {1,9,0,0}
    do_aw(4'h9, 32'h60, 4'd0, 3'd2, 2'd1);
    do_w(4'h9, 32'h99, 4'hF, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check_val("stall_hold", {24'd0, bus.BVALID, bus.BID, bus.BRESP, bus.AWREADY}, 32'hC8);
      @(posedge clk); #1;
    end
    do_b(4'h9, 2'd0);

    // Reset after beat 1 of a 4-beat burst
    do_aw(4'h2, 32'h80, 4'd3, 3'd2, 2'd1);
    do_w(4'h2, 32'hE0, 4'hF, 1'b0);
    do_w(4'h2, 32'hE1, 4'hF, 1'b0);
    rst = 1'b0;
    #1;
    check_val("midrst_wready",  {31'd0, bus.WREADY},  32'd0);
    check_val("midrst_awready", {31'd0, bus.AWREADY}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_val("rel_pre_awready", {31'd0, bus.AWREADY}, 32'd0);
    @(posedge clk); #1;
    check_val("rel_awready2", {31'd0, bus.AWREADY}, 32'd1);
    check_val("rel_bvalid",   {31'd0, bus.BVALID},  32'd0);
    rd_chk("midrst_w32", 8'd32, 32'hE0);
    rd_chk("midrst_w33", 8'd33, 32'hE1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
